mux3: RTL and testbench

Registered 3-to-1 data selector for the command-line-interface datapath. Chooses one of three 32-bit operand buses, data_1, data_2 or data_3, by a 2-bit select and presents the result on a registered output one clock later. The unused select code is flagged rather than silently aliased. The block also reports whether the output holds a freshly loaded value.

---
 rtl/mux3_if.sv | 37 +++
 rtl/mux3.sv | 47 ++++
 tb/tb_mux3.sv | 117 +++++++++++
 3 files changed

// File: rtl/mux3_if.sv
// mux3_if: operand/select bus and registered result bus of the 3-to-1 selector.
// The master side drives the operands, select and enable; the slave (mux3)
// returns the registered result together with its valid and error flags.
interface mux3_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic [WIDTH-1:0] data_3;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             sel_err;

    modport master (
        output en,
        output data_1,
        output data_2,
        output data_3,
        output sel,
        input  out_data,
        input  out_valid,
        input  sel_err
    );

    modport slave (
        input  en,
        input  data_1,
        input  data_2,
        input  data_3,
        input  sel,
        output out_data,
        output out_valid,
        output sel_err
    );
endinterface

// File: rtl/mux3.sv
// mux3: registered 3-to-1 data selector. One of three operand buses is copied
// bit-exact to out_data one clock after being selected. Select code 3 is not
// a valid operand: it leaves out_data untouched and raises sel_err instead.
// out_valid strobes for each cycle that follows a successful load.
module mux3 #(
    parameter int              WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic  clk,
    input logic  rst_n,
    mux3_if.slave bus
);

    // Result register: synchronous reset wins over enable; code 3 keeps the old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_data  <= RST_VAL;
            bus.out_valid <= 1'b0;
            bus.sel_err   <= 1'b0;
        end else if (bus.en) begin
            case (bus.sel)
                2'd0: begin
                    bus.out_data  <= bus.data_1;
                    bus.out_valid <= 1'b1;
                    bus.sel_err   <= 1'b0;
                end
                2'd1: begin
                    bus.out_data  <= bus.data_2;
                    bus.out_valid <= 1'b1;
                    bus.sel_err   <= 1'b0;
                end
                2'd2: begin
                    bus.out_data  <= bus.data_3;
                    bus.out_valid <= 1'b1;
                    bus.sel_err   <= 1'b0;
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    bus.sel_err   <= 1'b1;
                end
            endcase
        end else begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux3.sv
// tb_mux3: directed self-checking bench for the registered 3-to-1 selector.
module tb_mux3;

    logic clk;
    logic rst_n;
    int   checks_total;
    int   checks_passed;

    mux3_if #(.WIDTH(32)) bus ();

    mux3 #(
        .WIDTH   (32),
        .RST_VAL (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive a full input vector, then advance one rising edge and settle.
    task automatic applyStimulus(input logic rst_v, input logic en_v, input logic [1:0] sel_v,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] d3);
        rst_n      = rst_v;
        bus.en     = en_v;
        bus.sel    = sel_v;
        bus.data_1 = d1;
        bus.data_2 = d2;
        bus.data_3 = d3;
        @(posedge clk);
        #1;
    endtask

    // Compare all three outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic [31:0] exp_data,
                               input logic exp_valid, input logic exp_err);
        checks_total++;
        assert (bus.out_data === exp_data) checks_passed++;
        else $error("[TB] FAIL %s out_data: observed %h expected %h", tag, bus.out_data, exp_data);
        checks_total++;
        assert (bus.out_valid === exp_valid) checks_passed++;
        else $error("[TB] FAIL %s out_valid: observed %b expected %b", tag, bus.out_valid, exp_valid);
        checks_total++;
        assert (bus.sel_err === exp_err) checks_passed++;
        else $error("[TB] FAIL %s sel_err: observed %b expected %b", tag, bus.sel_err, exp_err);
    endtask

    // Directed sequence following the block's test plan.
    initial begin
        checks_total  = 0;
        checks_passed = 0;

        // Reset held for two edges while a load is requested.
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd1, 32'd2, 32'd3);
        checkOutput("reset_1", 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd1, 32'd1, 32'd2, 32'd3);
        checkOutput("reset_2", 32'd0, 1'b0, 1'b0);

        // Sweep the three legal codes.
        applyStimulus(1'b1, 1'b1, 2'd0, 32'd1, 32'd2, 32'd3);
        checkOutput("sweep_sel0", 32'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd1, 32'd1, 32'd2, 32'd3);
        checkOutput("sweep_sel1", 32'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd2, 32'd1, 32'd2, 32'd3);
        checkOutput("sweep_sel2", 32'd3, 1'b1, 1'b0);

        // Illegal code keeps the data and flags the error; a legal code clears it.
        applyStimulus(1'b1, 1'b1, 2'd3, 32'd1, 32'd2, 32'd3);
        checkOutput("illegal_sel3", 32'd3, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'd0, 32'd1, 32'd2, 32'd3);
        checkOutput("after_illegal", 32'd1, 1'b1, 1'b0);

        // Enable hold while data_3 toggles.
        applyStimulus(1'b1, 1'b1, 2'd1, 32'd1, 32'd2, 32'd3);
        checkOutput("hold_setup", 32'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 2'd2, 32'd1, 32'd2,
                          (i % 2 == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A);
            checkOutput("hold_en0", 32'd2, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 2'd2, 32'd1, 32'd2, 32'h1234_5678);
        checkOutput("hold_release", 32'h1234_5678, 1'b1, 1'b0);

        // sel_err holds while disabled, then reset clears it.
        applyStimulus(1'b1, 1'b1, 2'd3, 32'd1, 32'd2, 32'h1234_5678);
        checkOutput("err_set", 32'h1234_5678, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd1, 32'd2, 32'h1234_5678);
        checkOutput("err_hold_en0", 32'h1234_5678, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'd3, 32'd1, 32'd2, 32'h1234_5678);
        checkOutput("err_reset", 32'd0, 1'b0, 1'b0);

        // Reset mid-stream while streaming data_3.
        applyStimulus(1'b1, 1'b1, 2'd2, 32'd1, 32'd2, 32'hDEAD_BEEF);
        checkOutput("stream_load", 32'hDEAD_BEEF, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd2, 32'd1, 32'd2, 32'hDEAD_BEEF);
        checkOutput("stream_reset", 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd2, 32'd1, 32'd2, 32'hDEAD_BEEF);
        checkOutput("stream_resume", 32'hDEAD_BEEF, 1'b1, 1'b0);

        // Full-width patterns, alternating selects every cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, (i % 2 == 0) ? 2'd1 : 2'd0,
                          32'h8000_0001, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
            checkOutput("full_width", (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h8000_0001, 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
